// File: rtl/xorlfsr_stream_engine.sv
// XOR-LFSR stream cipher: DATA_WIDTH Fibonacci LFSR lanes each contribute one keystream
// bit per accepted word. The seed is staged word-serially and committed atomically.
module xorlfsr_stream_engine #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400
) (
    input  logic                  i_dataclk,
    input  logic                  i_resetn,
    input  logic [DATA_WIDTH-1:0] i_datain,
    input  logic                  i_seeddata,
    input  logic                  i_setseed,
    input  logic                  i_invalid,
    output logic                  o_inready,
    output logic [DATA_WIDTH-1:0] o_dataout,
    output logic                  o_outvalid,
    input  logic                  i_outready,
    output logic                  o_seeded,
    output logic [DATA_WIDTH-1:0] o_seedzero,
    output logic                  o_seederr,
    output logic [31:0]           o_beatcount
);

    localparam int BUF_W = DATA_WIDTH * LFSR_WIDTH;
    localparam int CNT_W = $clog2(LFSR_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LFSR_WIDTH);

    logic [BUF_W-1:0]                       r_buf;
    logic [CNT_W-1:0]                       r_seedcount;
    logic [DATA_WIDTH-1:0][LFSR_WIDTH-1:0]  r_lane;
    logic [DATA_WIDTH-1:0]                  r_dataout;
    logic                                   r_outvalid;
    logic                                   r_seeded;
    logic [DATA_WIDTH-1:0]                  r_seedzero;
    logic                                   r_seederr;
    logic [31:0]                            r_beatcount;

    logic                                   w_commit;
    logic                                   w_accept;
    logic                                   w_inready;
    logic [CNT_W-1:0]                       w_countNext;
    logic [DATA_WIDTH-1:0]                  w_keystream;
    logic [DATA_WIDTH-1:0]                  w_seedZero;
    logic [DATA_WIDTH-1:0][LFSR_WIDTH-1:0]  w_laneNext;
    logic [DATA_WIDTH-1:0][LFSR_WIDTH-1:0]  w_seedLoad;

    // setseed holds off acceptance, so commit and accept never share an edge
    assign w_commit  = i_setseed && (r_seedcount == CNT_FULL);
    assign w_inready = r_seeded & ~i_setseed & (~r_outvalid | i_outready);
    assign w_accept  = i_invalid & w_inready;

    always_comb begin
        w_keystream = '0;
        w_seedZero  = '0;
        w_laneNext  = '0;
        w_seedLoad  = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            w_keystream[k] = r_lane[k][LFSR_WIDTH-1];
            w_laneNext[k]  = {r_lane[k][LFSR_WIDTH-2:0], ^(r_lane[k] & TAPS)};
            w_seedZero[k]  = (r_buf[k*LFSR_WIDTH +: LFSR_WIDTH] == '0);
            w_seedLoad[k]  = w_seedZero[k] ? LFSR_WIDTH'(1)
                                           : r_buf[k*LFSR_WIDTH +: LFSR_WIDTH];
        end
    end

    // A commit empties the stage; a simultaneous shift then counts as the first new word
    always_comb begin
        w_countNext = r_seedcount;
        if (w_commit) begin
            w_countNext = i_seeddata ? CNT_W'(1) : '0;
        end else if (i_seeddata && (r_seedcount != CNT_FULL)) begin
            w_countNext = r_seedcount + CNT_W'(1);
        end
    end

    always_ff @(posedge i_dataclk) begin
        if (!i_resetn) begin
            r_buf       <= '0;
            r_seedcount <= '0;
        end else begin
            if (i_seeddata) begin
                r_buf <= {r_buf[BUF_W-DATA_WIDTH-1:0], i_datain};
            end
            r_seedcount <= w_countNext;
        end
    end

    always_ff @(posedge i_dataclk) begin
        if (!i_resetn) begin
            r_lane      <= '0;
            r_seeded    <= 1'b0;
            r_seedzero  <= '0;
            r_seederr   <= 1'b0;
            r_beatcount <= '0;
        end else begin
            r_seederr <= i_setseed & ~w_commit;
            if (w_commit) begin
                r_lane      <= w_seedLoad;
                r_seedzero  <= w_seedZero;
                r_seeded    <= 1'b1;
                r_beatcount <= '0;
            end else if (w_accept) begin
                r_lane      <= w_laneNext;
                r_beatcount <= r_beatcount + 32'd1;
            end
        end
    end

    always_ff @(posedge i_dataclk) begin
        if (!i_resetn) begin
            r_dataout  <= '0;
            r_outvalid <= 1'b0;
        end else if (w_accept) begin
            r_dataout  <= i_datain ^ w_keystream;
            r_outvalid <= 1'b1;
        end else if (r_outvalid && i_outready) begin
            r_outvalid <= 1'b0;
        end
    end

    assign o_inready   = w_inready;
    assign o_dataout   = r_dataout;
    assign o_outvalid  = r_outvalid;
    assign o_seeded    = r_seeded;
    assign o_seedzero  = r_seedzero;
    assign o_seederr   = r_seederr;
    assign o_beatcount = r_beatcount;

endmodule

// File: tb/tb_xorlfsr_stream_engine.sv
// Bench for xorlfsr_stream_engine: directed and random stimulus against a reference model
// that derives each keystream bit by stepping the committed seed from scratch.
module tb_xorlfsr_stream_engine;

    localparam int DW = 8;
    localparam int LW = 16;
    localparam logic [LW-1:0] TAPS = 16'hB400;

    logic          dataclk = 1'b0;
    logic          resetn;
    logic [DW-1:0] datain;
    logic          seeddata;
    logic          setseed;
    logic          invalid;
    logic          outready;
    logic          o_inready;
    logic [DW-1:0] o_dataout;
    logic          o_outvalid;
    logic          o_seeded;
    logic [DW-1:0] o_seedzero;
    logic          o_seederr;
    logic [31:0]   o_beatcount;

    int nChecks = 0;
    int nErrors = 0;

    xorlfsr_stream_engine #(.DATA_WIDTH(DW), .LFSR_WIDTH(LW), .TAPS(TAPS)) dut (
        .i_dataclk  (dataclk),
        .i_resetn   (resetn),
        .i_datain   (datain),
        .i_seeddata (seeddata),
        .i_setseed  (setseed),
        .i_invalid  (invalid),
        .o_inready  (o_inready),
        .o_dataout  (o_dataout),
        .o_outvalid (o_outvalid),
        .i_outready (outready),
        .o_seeded   (o_seeded),
        .o_seedzero (o_seedzero),
        .o_seederr  (o_seederr),
        .o_beatcount(o_beatcount)
    );

    always #5 dataclk = ~dataclk;

    // Reference model state: seeds per lane plus beats since commit
    logic [DW-1:0] mWords[$];
    logic [LW-1:0] mSeed[DW];
    int unsigned   mBeats;
    int            mCount;
    logic          mSeeded, mOutvalid, mSeederr, mActive = 1'b0;
    logic [DW-1:0] mSeedzero, mDataout;
    logic [DW-1:0] expQ[$];
    logic          mCommit, mAccept;
    logic [DW-1:0] mExp;
    logic [LW-1:0] mTmp;

    function automatic logic [LW-1:0] lfsrStep(input logic [LW-1:0] s);
        logic [LW-1:0] r;
        r = s << 1;
        r[0] = ($countones(s & TAPS) % 2) == 1;
        return r;
    endfunction

    function automatic logic [DW-1:0] keystream();
        logic [DW-1:0] ks;
        logic [LW-1:0] s;
        ks = '0;
        for (int k = 0; k < DW; k++) begin
            s = mSeed[k];
            for (int unsigned j = 0; j < mBeats; j++) s = lfsrStep(s);
            ks[k] = s[LW-1];
        end
        return ks;
    endfunction

    // Bit b of lane k sits at flat position k*LW+b; word 0 from the bottom is the newest
    function automatic logic [LW-1:0] seedOf(input int k);
        logic [LW-1:0] s;
        logic [DW-1:0] w;
        int pos;
        s = '0;
        for (int b = 0; b < LW; b++) begin
            pos = k * LW + b;
            w = mWords[LW - 1 - pos / DW];
            s[b] = w[pos % DW];
        end
        return s;
    endfunction

    always @(posedge dataclk) begin
        if (!resetn) begin
            mActive = 1'b1;
            mWords.delete();
            for (int i = 0; i < LW; i++) mWords.push_back('0);
            for (int k = 0; k < DW; k++) mSeed[k] = '0;
            mBeats = 0; mCount = 0; mSeeded = 0; mOutvalid = 0; mSeederr = 0;
            mSeedzero = '0; mDataout = '0;
            expQ.delete();
        end else if (mActive) begin
            mCommit  = setseed && (mCount == LW);
            mAccept  = invalid && mSeeded && !setseed && (!mOutvalid || outready);
            mSeederr = setseed && !mCommit;
            if (mCommit) begin
                mSeedzero = '0;
                for (int k = 0; k < DW; k++) begin
                    mTmp = seedOf(k);
                    if (mTmp == 0) begin
                        mTmp = 1;
                        mSeedzero[k] = 1'b1;
                    end
                    mSeed[k] = mTmp;
                end
                mSeeded = 1; mBeats = 0; mCount = 0;
            end
            if (mAccept) begin
                mExp = datain ^ keystream();
                expQ.push_back(mExp);
                mDataout = mExp; mOutvalid = 1; mBeats++;
            end else if (mOutvalid && outready) begin
                mOutvalid = 0;
            end
            if (seeddata) begin
                mWords.push_back(datain);
                void'(mWords.pop_front());
                if (mCount < LW) mCount++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle and pops the scoreboard on each consumption
    always @(negedge dataclk) begin
        if (mActive) begin
            checkOutput("inready", {31'd0, o_inready}, {31'd0, mSeeded & ~setseed & (~mOutvalid | outready)});
            checkOutput("outvalid", {31'd0, o_outvalid}, {31'd0, mOutvalid});
            checkOutput("seeded", {31'd0, o_seeded}, {31'd0, mSeeded});
            checkOutput("seedzero", {24'd0, o_seedzero}, {24'd0, mSeedzero});
            checkOutput("seederr", {31'd0, o_seederr}, {31'd0, mSeederr});
            checkOutput("beatcount", o_beatcount, mBeats);
            checkOutput("dataout", {24'd0, o_dataout}, {24'd0, mDataout});
            if (resetn && mOutvalid && outready) begin
                if (expQ.size() == 0) begin
                    nChecks++; nErrors++;
                    $display("[TB] FAIL scoreboard: output consumed with no expected word");
                end else begin
                    checkOutput("dataout_pop", {24'd0, o_dataout}, {24'd0, expQ.pop_front()});
                end
            end
        end
    end

    task automatic applyStimulus(input logic sd, input logic ss, input logic iv,
                                 input logic [DW-1:0] d, input logic ordy);
        seeddata = sd; setseed = ss; invalid = iv; datain = d; outready = ordy;
        @(posedge dataclk);
        #1;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        applyStimulus(0, 0, 0, '0, 1);
        resetn = 1'b1;
    endtask

    task automatic loadAce();
        for (int i = 0; i < LW; i++) applyStimulus(1, 0, 0, (i % 2) ? 8'hE1 : 8'hAC, 1);
        applyStimulus(0, 1, 0, '0, 1);
    endtask

    logic [DW-1:0] tp1Exp[3] = '{8'hFF, 8'h00, 8'hFF};

    initial begin
        resetn = 1'b0; seeddata = 0; setseed = 0; invalid = 0; datain = '0; outready = 1;
        applyStimulus(0, 0, 0, '0, 1);
        applyStimulus(0, 0, 0, '0, 1);
        resetn = 1'b1;
        checkOutput("reset_inready", {31'd0, o_inready}, 32'd0);

        $display("[TB] known-seed stream");
        loadAce();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 8'h00, 1);
            checkOutput("tp1_dataout", {24'd0, o_dataout}, {24'd0, tp1Exp[i]});
        end
        checkOutput("tp1_beatcount", o_beatcount, 32'd3);
        applyStimulus(0, 0, 0, '0, 1);

        $display("[TB] back-pressure");
        loadAce();
        applyStimulus(0, 0, 1, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 8'h00, 0);
            checkOutput("stall_dataout", {24'd0, o_dataout}, 32'hFF);
            checkOutput("stall_inready", {31'd0, o_inready}, 32'd0);
        end
        applyStimulus(0, 0, 1, 8'h00, 1);
        checkOutput("release_dataout1", {24'd0, o_dataout}, 32'h00);
        applyStimulus(0, 0, 1, 8'h00, 1);
        checkOutput("release_dataout2", {24'd0, o_dataout}, 32'hFF);
        applyStimulus(0, 0, 0, '0, 1);

        $display("[TB] zero seed");
        doReset();
        for (int i = 0; i < LW; i++) applyStimulus(1, 0, 0, 8'h00, 1);
        applyStimulus(0, 1, 0, '0, 1);
        checkOutput("zero_seedzero", {24'd0, o_seedzero}, 32'hFF);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 1, 8'h5A, 1);
            checkOutput("zero_dataout", {24'd0, o_dataout}, (i < 15) ? 32'h5A : 32'hA5);
        end
        applyStimulus(0, 0, 0, '0, 1);

        $display("[TB] partial seed");
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, DW'($urandom), 1);
        applyStimulus(0, 1, 0, '0, 1);
        checkOutput("partial_seederr", {31'd0, o_seederr}, 32'd1);
        checkOutput("partial_seeded", {31'd0, o_seeded}, 32'd0);
        applyStimulus(0, 0, 1, 8'h33, 1);
        checkOutput("partial_seederr_drop", {31'd0, o_seederr}, 32'd0);
        checkOutput("partial_inready", {31'd0, o_inready}, 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, DW'($urandom), 1);
        applyStimulus(0, 1, 0, '0, 1);
        checkOutput("partial_commit", {31'd0, o_seeded}, 32'd1);

        $display("[TB] mid-stream rekey");
        for (int i = 0; i < LW; i++) applyStimulus(1, 0, 1, DW'($urandom), 1);
        applyStimulus(0, 1, 0, '0, 0);
        checkOutput("rekey_beatcount", o_beatcount, 32'd0);
        checkOutput("rekey_pending", {31'd0, o_outvalid}, 32'd1);
        applyStimulus(0, 0, 1, DW'($urandom), 1);
        checkOutput("rekey_beat1", o_beatcount, 32'd1);
        applyStimulus(0, 0, 0, '0, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(99) != 0);
            applyStimulus($urandom_range(1), $urandom_range(19) == 0, $urandom_range(3) != 0,
                          DW'($urandom), $urandom_range(3) != 0);
        end
        resetn = 1'b1;

        $display("[TB] reset mid-stream");
        doReset();
        for (int i = 0; i < LW; i++) applyStimulus(1, 0, 0, DW'($urandom), 1);
        applyStimulus(0, 1, 0, '0, 1);
        applyStimulus(0, 0, 1, DW'($urandom), 0);
        applyStimulus(0, 0, 1, DW'($urandom), 0);
        resetn = 1'b0;
        applyStimulus(0, 0, 1, DW'($urandom), 1);
        checkOutput("rst_outvalid", {31'd0, o_outvalid}, 32'd0);
        checkOutput("rst_dataout", {24'd0, o_dataout}, 32'd0);
        checkOutput("rst_seeded", {31'd0, o_seeded}, 32'd0);
        checkOutput("rst_inready", {31'd0, o_inready}, 32'd0);
        resetn = 1'b1;
        applyStimulus(0, 0, 1, '0, 1);
        applyStimulus(0, 0, 0, '0, 1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
